conversor_2_tx: RTL and testbench
=================================

Name: conversor_2_tx

Overview:
- Transmit-side counterpart of the 4-bit code converter. It accepts a decimal digit (0-9) over a valid/ready handshake and encodes it into the team's 4-bit code word H,G,F,E.
- It then shifts the code word out on a single serial line, framed with start, parity and stop bits.
- It sits upstream of the serial link whose receive side decodes H,G,F,E back to the digit D,C,B,A.

Parameters:
- BIT_DIV, 4: clock cycles per serial bit; legal range 1..255.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity over the 4 code bits.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- din_valid  in  1  digit present on din.
- din  in  4  decimal digit, binary; 0-9 legal.
- din_ready  out  1  block can accept a digit this cycle.
- tx  out  1  serial line; idles high.
- tx_busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.
- err_invalid  out  1  one-cycle pulse after an illegal digit (10-15) is accepted.
- code_out  out  4  last encoded code word, packed as {H,G,F,E}.
- digits_sent  out  8  count of completed frames; wraps.

Behaviour:
- Encoding table, digit -> HGFE: 0->0000, 1->0001, 2->0010, 3->0100, 4->0101, 5->0111, 6->1000, 7->1010, 8->1100, 9->1101.
- Reset values, applied asynchronously on rst=1: tx=1, din_ready=1, tx_busy=0, frame_done=0, err_invalid=0, code_out=0000, digits_sent=0. State goes to IDLE; bit and divider counters clear.
- Reset mid-frame: the frame is abandoned with no frame_done, and tx returns to 1 immediately.
- States: IDLE, START, DATA, PARITY, STOP.
- din_ready = 1 only in IDLE. A transfer occurs on a rising edge where din_valid=1 and din_ready=1; din is latched at that edge.
- Accepting a legal digit:
  - Next cycle: state=START, tx=0, tx_busy=1, code_out=encoded word.
  - tx goes low exactly 1 cycle after the accepting edge.
- Accepting an illegal digit (10-15):
  - Digit is consumed; state stays IDLE.
  - err_invalid=1 for exactly the next cycle.
  - tx, code_out and digits_sent are unchanged; din_ready stays 1.
- Frame sequence, each bit held BIT_DIV cycles, using a divider counter from 0 to BIT_DIV-1:
  - START (0).
  - DATA: H, G, F, E, MSB first; a 2-bit index counts 3 down to 0.
  - PARITY: XOR of the code bits, inverted when PARITY_ODD=1.
  - STOP (1).
  - Frame length is 7*BIT_DIV cycles.
- frame_done=1 during the final STOP cycle; digits_sent increments on the same edge that leaves STOP. 255 -> 0 wrap.
- After STOP the state is IDLE: din_ready=1 and tx_busy=0 on the cycle after the final STOP cycle.
- Accept-to-next-accept minimum is 7*BIT_DIV+1 cycles. No back-to-back overlap.
- din/din_valid changes while busy are ignored. A digit held valid is accepted on the first din_ready=1 cycle.
- BIT_DIV=1: each state lasts one cycle, and DATA lasts 4 cycles.
- tx is registered, so no combinational path exists from din to tx.

Test Plan:
- Reset: pulse rst while clk is running, and again asynchronously between edges. Required: tx=1, din_ready=1, tx_busy=0, code_out=0000, digits_sent=0 immediately.
- Digit 5, BIT_DIV=4, even parity:
  - code_out=0111.
  - tx from the cycle after accept is 0,0,1,1,1,1,1 (start, H,G,F,E, parity=1, stop), each held 4 cycles.
  - frame_done is high on cycle 28 after accept; digits_sent=1; din_ready=1 on cycle 29.
- Digit 12 presented in IDLE: err_invalid=1 for one cycle; tx stays 1; tx_busy=0; code_out and digits_sent unchanged.
- Digit 9, then din_valid held with din=3 during the frame:
  - 3 is not accepted until din_ready rises.
  - Frames: 1101 with parity 1, then 0100 with parity 1.
  - digits_sent=2.
- rst asserted during the DATA bit G of digit 8: tx=1 asynchronously; no frame_done; digits_sent=0; the next digit frames normally.
- PARITY_ODD=1, BIT_DIV=1:
  - Digit 0 gives tx sequence 0,0,0,0,0,1,1.
  - After 256 such frames, digits_sent=0 (wrap).

Source files
------------

// File: rtl/conversor_2_tx.sv
// Serial transmitter: takes a decimal digit over valid/ready, encodes it to the 4-bit
// HGFE code word and sends it as start, H, G, F, E, parity, stop on a registered tx line.
module conversor_2_tx #(
    parameter int BIT_DIV    = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_valid,
    input  logic [3:0] din,
    output logic       din_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       err_invalid,
    output logic [3:0] code_out,
    output logic [7:0] digits_sent
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);

    state_t     r_state;
    logic [7:0] r_div;
    logic [1:0] r_idx;
    logic [3:0] r_code;
    logic [7:0] r_cnt;
    logic       r_err;
    logic       r_tx;

    state_t     w_state_next;
    logic [7:0] w_div_next;
    logic [1:0] w_idx_next;
    logic [3:0] w_code_next;
    logic [7:0] w_cnt_next;
    logic       w_err_next;
    logic       w_tx_next;
    logic       w_div_last;

    function automatic logic [3:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 4'b0000;
            4'd1:    encode = 4'b0001;
            4'd2:    encode = 4'b0010;
            4'd3:    encode = 4'b0100;
            4'd4:    encode = 4'b0101;
            4'd5:    encode = 4'b0111;
            4'd6:    encode = 4'b1000;
            4'd7:    encode = 4'b1010;
            4'd8:    encode = 4'b1100;
            4'd9:    encode = 4'b1101;
            default: encode = 4'b0000;
        endcase
    endfunction

    assign w_div_last = (r_div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_div   <= 8'd0;
            r_idx   <= 2'd0;
            r_code  <= 4'd0;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_idx   <= w_idx_next;
            r_code  <= w_code_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_idx_next   = r_idx;
        w_code_next  = r_code;
        w_cnt_next   = r_cnt;
        w_err_next   = 1'b0;
        w_tx_next    = 1'b1;

        if (r_state != IDLE) begin
            w_div_next = w_div_last ? 8'd0 : r_div + 8'd1;
        end

        case (r_state)
            IDLE: begin
                if (din_valid) begin
                    if (din <= 4'd9) begin
                        w_state_next = START;
                        w_div_next   = 8'd0;
                        w_code_next  = encode(din);
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            START: begin
                if (w_div_last) begin
                    w_state_next = DATA;
                    w_idx_next   = 2'd3;
                end
            end
            DATA: begin
                if (w_div_last) begin
                    if (r_idx == 2'd0) begin
                        w_state_next = PARITY;
                    end else begin
                        w_idx_next = r_idx - 2'd1;
                    end
                end
            end
            PARITY: begin
                if (w_div_last) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_div_last) begin
                    w_state_next = IDLE;
                    w_cnt_next   = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // tx is registered from the next state so the line level lines up with the state.
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_code_next[w_idx_next];
            PARITY:  w_tx_next = (^w_code_next) ^ PARITY_ODD;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign din_ready   = (r_state == IDLE);
    assign tx_busy     = (r_state != IDLE);
    assign frame_done  = (r_state == STOP) && w_div_last;
    assign err_invalid = r_err;
    assign tx          = r_tx;
    assign code_out    = r_code;
    assign digits_sent = r_cnt;

endmodule

// File: tb/tb_conversor_2_tx.sv
// Directed bench for conversor_2_tx: table of legal digits plus hand-written sequences
// for illegal input, held-valid, mid-frame reset and the BIT_DIV=1 odd-parity wrap.
module tb_conversor_2_tx;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid, din_valid1;
    logic [3:0] din, din1;
    logic       din_ready, tx, tx_busy, frame_done, err_invalid;
    logic [3:0] code_out;
    logic [7:0] digits_sent;
    logic       din_ready1, tx1, tx_busy1, frame_done1, err_invalid1;
    logic [3:0] code_out1;
    logic [7:0] digits_sent1;

    int checks = 0;
    int errors = 0;
    int sent_exp = 0;

    always #5 clk = ~clk;

    conversor_2_tx #(.BIT_DIV(BD), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready),
        .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done), .err_invalid(err_invalid),
        .code_out(code_out), .digits_sent(digits_sent)
    );

    conversor_2_tx #(.BIT_DIV(1), .PARITY_ODD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .din_valid(din_valid1), .din(din1), .din_ready(din_ready1),
        .tx(tx1), .tx_busy(tx_busy1), .frame_done(frame_done1), .err_invalid(err_invalid1),
        .code_out(code_out1), .digits_sent(digits_sent1)
    );

    typedef struct {
        logic [3:0] digit;
        logic [3:0] code;
        logic       par;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [3:0] code_exp, input int cnt_exp);
        chk({tag, " tx"}, 32'(tx), 32'd1);
        chk({tag, " din_ready"}, 32'(din_ready), 32'd1);
        chk({tag, " tx_busy"}, 32'(tx_busy), 32'd0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, " code_out"}, 32'(code_out), 32'(code_exp));
        chk({tag, " digits_sent"}, 32'(digits_sent), 32'(cnt_exp));
    endtask

    // Entered at the negedge of cycle 1 after the accepting edge; leaves at cycle 7*BD+1.
    task automatic check_frame(input logic [3:0] code, input logic par);
        logic [6:0] seq;
        seq = {1'b0, code, par, 1'b1};
        chk("code_out", 32'(code_out), 32'(code));
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < BD; j++) begin
                chk($sformatf("tx bit%0d cyc%0d", k, j), 32'(tx), 32'(seq[6-k]));
                chk("tx_busy", 32'(tx_busy), 32'd1);
                chk("din_ready busy", 32'(din_ready), 32'd0);
                chk("frame_done", 32'(frame_done), 32'((k == 6) && (j == BD - 1)));
                @(negedge clk);
            end
        end
        sent_exp = (sent_exp + 1) % 256;
        chk("digits_sent after frame", 32'(digits_sent), 32'(sent_exp));
        chk("din_ready after frame", 32'(din_ready), 32'd1);
        chk("tx_busy after frame", 32'(tx_busy), 32'd0);
    endtask

    task automatic send(input logic [3:0] d);
        din = d;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'd0, 4'b0000, 1'b0};
        vecs[1] = '{4'd1, 4'b0001, 1'b1};
        vecs[2] = '{4'd2, 4'b0010, 1'b1};
        vecs[3] = '{4'd3, 4'b0100, 1'b1};
        vecs[4] = '{4'd4, 4'b0101, 1'b0};
        vecs[5] = '{4'd5, 4'b0111, 1'b1};
        vecs[6] = '{4'd6, 4'b1000, 1'b1};
        vecs[7] = '{4'd7, 4'b1010, 1'b0};
        vecs[8] = '{4'd8, 4'b1100, 1'b0};
        vecs[9] = '{4'd9, 4'b1101, 1'b1};

        rst = 1'b1;
        din_valid = 1'b0; din = 4'd0;
        din_valid1 = 1'b0; din1 = 4'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 4'd0, 0);
        chk("reset err_invalid", 32'(err_invalid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table of all legal digits, one frame each.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].digit);
            check_frame(vecs[i].code, vecs[i].par);
            $display("digit %0d code %b parity %0d sent %0d", vecs[i].digit, vecs[i].code,
                     vecs[i].par, digits_sent);
        end

        // Illegal digit: consumed, one-cycle error pulse, nothing else moves.
        send(4'd12);
        chk("err_invalid pulse", 32'(err_invalid), 32'd1);
        check_idle_outputs("illegal", 4'b1101, sent_exp);
        @(negedge clk);
        chk("err_invalid cleared", 32'(err_invalid), 32'd0);
        check_idle_outputs("illegal+1", 4'b1101, sent_exp);
        $display("illegal digit 12 err pulse checked");

        // Digit 9 then 3 held valid through the frame.
        din = 4'd9;
        din_valid = 1'b1;
        @(negedge clk);
        din = 4'd3;
        check_frame(4'b1101, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        check_frame(4'b0100, 1'b1);
        $display("held digit 9 then 3, sent %0d", digits_sent);

        // Asynchronous reset in the middle of bit G of digit 8.
        send(4'd8);
        repeat (BD + BD + 1) @(negedge clk);
        chk("pre-reset tx_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async reset", 4'd0, 0);
        sent_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 7 * BD + 2; c++) begin
            chk("no frame_done after reset", 32'(frame_done), 32'd0);
            @(negedge clk);
        end
        chk("digits_sent after abort", 32'(digits_sent), 32'd0);
        send(4'd5);
        check_frame(4'b0111, 1'b1);
        $display("reset mid-frame then digit 5, sent %0d", digits_sent);

        // BIT_DIV=1, odd parity: digit 0 frames back to back until the counter wraps.
        din1 = 4'd0;
        din_valid1 = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 256; f++) begin
            for (int k = 0; k < 7; k++) begin
                if (f == 0) begin
                    chk($sformatf("fast tx bit%0d", k), 32'(tx1), 32'(k >= 5));
                    chk("fast frame_done", 32'(frame_done1), 32'(k == 6));
                end
                @(negedge clk);
            end
            chk("fast digits_sent", 32'(digits_sent1), 32'((f + 1) % 256));
            chk("fast din_ready", 32'(din_ready1), 32'd1);
            @(negedge clk);
        end
        din_valid1 = 1'b0;
        chk("fast wrap", 32'(digits_sent1), 32'd0);
        $display("fast instance 256 frames, sent %0d", digits_sent1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
